// File: rtl/wb_spi_regif_if.sv
// rtl/wb_spi_regif_if.sv - Wishbone classic bus bundle for the SPI register front-end
interface wb_spi_regif_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic              wb_stb;
  logic              wb_cyc;
  logic [DATA_W-1:0] wb_dout;
  logic [DATA_W-1:0] wb_din;
  logic              wb_ack;
  logic              wb_err;

  modport master (
    output wb_addr, wb_we, wb_stb, wb_cyc, wb_dout,
    input  wb_din, wb_ack, wb_err
  );

  modport slave (
    input  wb_addr, wb_we, wb_stb, wb_cyc, wb_dout,
    output wb_din, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_spi_regif.sv
// rtl/wb_spi_regif.sv - Wishbone classic register front-end for the SPI core
// Decodes DATA/CMD/STAT, strobes the core, waits for its ack with a timeout, keeps sticky status.
module wb_spi_regif #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                CORE_DW   = 12,
  parameter int                CORE_RW   = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] OFF_DATA  = 'h10,
  parameter logic [ADDR_W-1:0] OFF_CMD   = 'h20,
  parameter logic [ADDR_W-1:0] OFF_STAT  = 'h30,
  parameter int                TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  wb_spi_regif_if.slave      bus,
  output logic [CORE_DW-1:0] dout,
  output logic               cmd,
  output logic               wr,
  output logic               rd,
  input  logic [CORE_RW-1:0] din,
  input  logic               ack
);

  localparam int                CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_DATA = BASE_ADDR + OFF_DATA;
  localparam logic [ADDR_W-1:0] ADDR_CMD  = BASE_ADDR + OFF_CMD;
  localparam logic [ADDR_W-1:0] ADDR_STAT = BASE_ADDR + OFF_STAT;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               to_flag, to_flag_n;
  logic [7:0]         err_cnt, err_cnt_n;
  logic               err_inc, stat_clr;
  logic [DATA_W-1:0]  wb_din_n;
  logic               wb_ack_n, wb_err_n;
  logic [CORE_DW-1:0] dout_n;
  logic               cmd_n, wr_n, rd_n;
  logic               sel, hit_data, hit_cmd, hit_stat, strobing;
  logic               unused_wdata;

  assign sel      = bus.wb_stb & bus.wb_cyc;
  assign hit_data = (bus.wb_addr == ADDR_DATA);
  assign hit_cmd  = (bus.wb_addr == ADDR_CMD);
  assign hit_stat = (bus.wb_addr == ADDR_STAT);
  // A core ack that coincides with our own strobe belongs to nothing we issued.
  assign strobing = cmd | wr | rd;
  assign unused_wdata = ^bus.wb_dout;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    to_flag_n = to_flag;
    err_inc   = 1'b0;
    stat_clr  = 1'b0;
    wb_din_n  = bus.wb_din;
    wb_ack_n  = 1'b0;
    wb_err_n  = 1'b0;
    dout_n    = dout;
    cmd_n     = 1'b0;
    wr_n      = 1'b0;
    rd_n      = 1'b0;

    case (state)
      IDLE: begin
        if (sel) begin
          if (hit_data) begin
            if (bus.wb_we) begin
              dout_n = bus.wb_dout[CORE_DW-1:0];
              wr_n   = 1'b1;
            end else begin
              rd_n   = 1'b1;
            end
            cnt_n   = '0;
            state_n = WAIT;
          end else if (hit_cmd && bus.wb_we) begin
            dout_n  = bus.wb_dout[CORE_DW-1:0];
            cmd_n   = 1'b1;
            cnt_n   = '0;
            state_n = WAIT;
          end else if (hit_stat) begin
            if (bus.wb_we) begin
              stat_clr = bus.wb_dout[0];
            end else begin
              wb_din_n = DATA_W'({err_cnt, to_flag});
            end
            wb_ack_n = 1'b1;
            state_n  = RESP;
          end else begin
            wb_err_n = 1'b1;
            err_inc  = 1'b1;
            state_n  = RESP;
          end
        end
      end

      WAIT: begin
        if (!bus.wb_cyc) begin
          state_n = IDLE;
        end else if (ack && !strobing) begin
          wb_din_n = DATA_W'(din);
          wb_ack_n = 1'b1;
          state_n  = RESP;
        end else if (cnt == CNT_LAST) begin
          to_flag_n = 1'b1;
          err_inc   = 1'b1;
          wb_err_n  = 1'b1;
          state_n   = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Status write-1-to-clear takes precedence; the counter never wraps.
    if (stat_clr) begin
      to_flag_n = 1'b0;
      err_cnt_n = '0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_cnt_n = err_cnt + 8'd1;
    end else begin
      err_cnt_n = err_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      to_flag    <= 1'b0;
      err_cnt    <= '0;
      bus.wb_din <= '0;
      bus.wb_ack <= 1'b0;
      bus.wb_err <= 1'b0;
      dout       <= '0;
      cmd        <= 1'b0;
      wr         <= 1'b0;
      rd         <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      to_flag    <= to_flag_n;
      err_cnt    <= err_cnt_n;
      bus.wb_din <= wb_din_n;
      bus.wb_ack <= wb_ack_n;
      bus.wb_err <= wb_err_n;
      dout       <= dout_n;
      cmd        <= cmd_n;
      wr         <= wr_n;
      rd         <= rd_n;
    end
  end

endmodule

// File: tb/tb_wb_spi_regif.sv
// tb/tb_wb_spi_regif.sv - self-checking bench for wb_spi_regif
// Latencies and register contents are predicted from the register-block rules, not the FSM.
module tb_wb_spi_regif;

  localparam logic [31:0] A_DATA = 32'h10;
  localparam logic [31:0] A_CMD  = 32'h20;
  localparam logic [31:0] A_STAT = 32'h30;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] dout;
  logic        cmd, wr, rd;
  logic [9:0]  core_din = '0;
  logic        core_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  int          m_err_cnt = 0;
  logic        m_to_flag = 1'b0;
  logic [11:0] m_dout    = '0;
  logic [31:0] m_wb_din  = '0;

  wb_spi_regif_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wb_spi_regif dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .dout (dout),
    .cmd  (cmd),
    .wr   (wr),
    .rd   (rd),
    .din  (core_din),
    .ack  (core_ack)
  );

  always #5 clk = ~clk;

  // One bus access; the core acks d cycles after its strobe (d < 0: never).
  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] data,
                           input int d, input logic [9:0] cdata,
                           output logic got_ack, output logic got_err, output int lat,
                           output logic [31:0] rdata, output int n_cmd, output int n_wr,
                           output int n_rd);
    int p;
    p = -1; got_ack = 0; got_err = 0; lat = -1; rdata = '0; n_cmd = 0; n_wr = 0; n_rd = 0;
    @(negedge clk);
    bus.wb_addr = addr; bus.wb_we = we; bus.wb_dout = data; bus.wb_stb = 1; bus.wb_cyc = 1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      core_ack = 1'b0;
      if (cmd) n_cmd++;
      if (wr)  n_wr++;
      if (rd)  n_rd++;
      if (cmd | wr | rd) p = n;
      if (bus.wb_ack | bus.wb_err) begin
        got_ack = bus.wb_ack; got_err = bus.wb_err; lat = n; rdata = bus.wb_din;
      end
      if (p >= 0 && d >= 0 && n == p + d) begin
        core_ack = 1'b1; core_din = cdata;
      end
    end
    bus.wb_stb = 0; bus.wb_cyc = 0; core_ack = 1'b0;
  endtask

  function automatic logic [31:0] m_stat();
    return {23'd0, 8'(m_err_cnt), m_to_flag};
  endfunction

  task automatic m_error(input logic is_timeout);
    if (is_timeout) m_to_flag = 1'b1;
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  task automatic test_reset();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    bus.wb_addr = '0; bus.wb_we = 0; bus.wb_stb = 0; bus.wb_cyc = 0; bus.wb_dout = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.wb_din, bus.wb_ack, bus.wb_err, dout, cmd, wr, rd} !== '0) begin
        fails++; $display("FAIL reset_outputs cycle %0d: got din=%h ack=%b err=%b dout=%h cmd=%b wr=%b rd=%b expected all 0",
                          i, bus.wb_din, bus.wb_ack, bus.wb_err, dout, cmd, wr, rd);
      end
    end
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    tests++;
    if ({ga, ge, lat == 1, rdv} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      fails++; $display("FAIL reset_stat_read: got ack=%b err=%b lat=%0d data=%h expected ack=1 err=0 lat=1 data=0",
                        ga, ge, lat, rdv);
    end
  endtask

  task automatic test_write();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    do_access(A_DATA, 1, 32'h0000_0ABC, 3, 10'h155, ga, ge, lat, rdv, nc, nw, nr);
    m_dout = 12'hABC; m_wb_din = 32'h155;
    tests++;
    if ({ga, ge, 8'(lat), 8'(nw), 8'(nc), 8'(nr)} !== {1'b1, 1'b0, 8'd5, 8'd1, 8'd0, 8'd0}) begin
      fails++; $display("FAIL write_data: got ack=%b err=%b lat=%0d wr=%0d cmd=%0d rd=%0d expected 1 0 5 1 0 0",
                        ga, ge, lat, nw, nc, nr);
    end
    tests++;
    if (dout !== 12'hABC) begin
      fails++; $display("FAIL write_dout: got %h expected abc", dout);
    end
    @(negedge clk);
    tests++;
    if (bus.wb_ack !== 1'b0) begin
      fails++; $display("FAIL write_ack_width: got wb_ack=%b one cycle later expected 0", bus.wb_ack);
    end
  endtask

  task automatic test_read();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    do_access(A_DATA, 0, '0, 1, 10'h3FF, ga, ge, lat, rdv, nc, nw, nr);
    m_wb_din = 32'h3FF;
    tests++;
    if ({ga, ge, 8'(lat), 8'(nr), 8'(nw), 8'(nc), rdv} !== {1'b1, 1'b0, 8'd3, 8'd1, 8'd0, 8'd0, 32'h3FF}) begin
      fails++; $display("FAIL read_data: got ack=%b err=%b lat=%0d rd=%0d wr=%0d cmd=%0d data=%h expected 1 0 3 1 0 0 3ff",
                        ga, ge, lat, nr, nw, nc, rdv);
    end
  endtask

  task automatic test_timeout();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    do_access(A_CMD, 1, 32'h0000_0555, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_dout = 12'h555; m_error(1'b1);
    tests++;
    if ({ga, ge, 8'(lat), 8'(nc)} !== {1'b0, 1'b1, 8'(1 + TMO), 8'd1}) begin
      fails++; $display("FAIL timeout_err: got ack=%b err=%b lat=%0d cmd=%0d expected 0 1 %0d 1",
                        ga, ge, lat, nc, 1 + TMO);
    end
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    tests++;
    if (rdv !== 32'h0000_0003) begin
      fails++; $display("FAIL timeout_stat: got %h expected 00000003", rdv);
    end
    do_access(A_STAT, 1, 32'h1, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_to_flag = 1'b0; m_err_cnt = 0; m_wb_din = '0;
    tests++;
    if ({ga, rdv} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL stat_clear: got ack=%b data=%h expected ack=1 data=0", ga, rdv);
    end
  endtask

  task automatic test_unmapped();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    do_access(32'h40, 1, 32'hFFFF_FFFF, 0, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_error(1'b0);
    tests++;
    if ({ga, ge, 8'(lat), 8'(nc + nw + nr), dout} !== {1'b0, 1'b1, 8'd1, 8'd0, m_dout}) begin
      fails++; $display("FAIL unmapped_err: got ack=%b err=%b lat=%0d strobes=%0d dout=%h expected 0 1 1 0 %h",
                        ga, ge, lat, nc + nw + nr, dout, m_dout);
    end
    do_access(A_CMD, 0, '0, 0, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_error(1'b0);
    tests++;
    if ({ga, ge, 8'(nc + nw + nr)} !== {1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL cmd_read_unmapped: got ack=%b err=%b strobes=%0d expected 0 1 0", ga, ge, nc + nw + nr);
    end
    for (int i = 0; i < 300; i++) begin
      do_access(32'h40 + 32'(i % 7) * 4, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
      m_error(1'b0);
    end
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_wb_din = m_stat();
    tests++;
    if (rdv !== 32'h0000_01FE || rdv !== m_wb_din) begin
      fails++; $display("FAIL err_cnt_saturate: got %h expected 000001fe", rdv);
    end
  endtask

  task automatic test_abort();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    int n_rd, n_resp;
    n_rd = 0; n_resp = 0;
    @(negedge clk);
    bus.wb_addr = A_DATA; bus.wb_we = 0; bus.wb_stb = 1; bus.wb_cyc = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      core_ack = 1'b0;
      if (rd) n_rd++;
      if (bus.wb_ack | bus.wb_err) n_resp++;
      if (n == 3) begin bus.wb_stb = 0; bus.wb_cyc = 0; end
      if (n == 5) begin core_ack = 1'b1; core_din = 10'h2AA; end
    end
    tests++;
    if ({8'(n_rd), 8'(n_resp)} !== {8'd1, 8'd0}) begin
      fails++; $display("FAIL abort: got rd=%0d responses=%0d expected rd=1 responses=0", n_rd, n_resp);
    end
    do_access(A_DATA, 1, 32'h0000_0123, 2, 10'h0F0, ga, ge, lat, rdv, nc, nw, nr);
    m_dout = 12'h123; m_wb_din = 32'h0F0;
    tests++;
    if ({ga, ge, 8'(lat), dout, rdv} !== {1'b1, 1'b0, 8'd4, 12'h123, 32'h0F0}) begin
      fails++; $display("FAIL after_abort: got ack=%b err=%b lat=%0d dout=%h data=%h expected 1 0 4 123 0f0",
                        ga, ge, lat, dout, rdv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int idx, n_wr, n_ack, last, ack_at;
    vals[0] = 32'h0000_0111; vals[1] = 32'h0000_0222; vals[2] = 32'h0000_0333;
    idx = 0; n_wr = 0; n_ack = 0; last = -1; ack_at = -1;
    @(negedge clk);
    bus.wb_addr = A_DATA; bus.wb_we = 1; bus.wb_dout = vals[0]; bus.wb_stb = 1; bus.wb_cyc = 1;
    for (int n = 1; n <= 60 && idx < 3; n++) begin
      @(negedge clk);
      core_ack = 1'b0;
      if (wr) begin
        n_wr++; ack_at = n + 1;
        tests++;
        if (dout !== vals[idx][11:0]) begin
          fails++; $display("FAIL b2b_dout %0d: got %h expected %h", idx, dout, vals[idx][11:0]);
        end
      end
      if (n == ack_at) begin core_ack = 1'b1; core_din = 10'(idx); end
      if (bus.wb_ack) begin
        n_ack++; idx++; last = n;
        if (idx < 3) bus.wb_dout = vals[idx];
        else begin bus.wb_stb = 0; bus.wb_cyc = 0; end
      end
    end
    bus.wb_stb = 0; bus.wb_cyc = 0; core_ack = 1'b0;
    m_dout = 12'h333; m_wb_din = 32'h2;
    tests++;
    if ({8'(n_wr), 8'(n_ack), 8'(last)} !== {8'd3, 8'd3, 8'd11}) begin
      fails++; $display("FAIL b2b_timing: got wr=%0d acks=%0d last_ack=%0d expected 3 3 11", n_wr, n_ack, last);
    end
  endtask

  task automatic test_random();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    logic [31:0] addr, data; logic we; int kind, d; logic [9:0] cd;
    logic e_ack, e_err; int e_lat, e_c, e_w, e_r;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      we   = 1'($urandom_range(0, 1));
      data = $urandom;
      cd   = 10'($urandom_range(0, 1023));
      d    = $urandom_range(0, 6);
      if (d == 6) d = -1;
      case (kind)
        0: addr = A_DATA;
        1: addr = A_CMD;
        2: begin addr = A_STAT; if ($urandom_range(0, 3) != 0) data[0] = 1'b0; end
        default: addr = 32'h100 + 32'($urandom_range(0, 255));
      endcase
      do_access(addr, we, data, d, cd, ga, ge, lat, rdv, nc, nw, nr);
      e_c = 0; e_w = 0; e_r = 0;
      if (addr == A_STAT) begin
        e_ack = 1; e_err = 0; e_lat = 1;
        if (!we) m_wb_din = m_stat();
        else if (data[0]) begin m_to_flag = 0; m_err_cnt = 0; end
      end else if (addr == A_DATA || (addr == A_CMD && we)) begin
        if (addr == A_CMD) e_c = 1; else if (we) e_w = 1; else e_r = 1;
        if (we) m_dout = data[11:0];
        if (d >= 1 && d <= TMO - 1) begin
          e_ack = 1; e_err = 0; e_lat = 2 + d; m_wb_din = 32'(cd);
        end else begin
          e_ack = 0; e_err = 1; e_lat = 1 + TMO; m_error(1'b1);
        end
      end else begin
        e_ack = 0; e_err = 1; e_lat = 1; m_error(1'b0);
      end
      tests++;
      if ({ga, ge, 8'(lat), 8'(nc), 8'(nw), 8'(nr)} !== {e_ack, e_err, 8'(e_lat), 8'(e_c), 8'(e_w), 8'(e_r)}) begin
        fails++; $display("FAIL rand_resp %0d addr=%h we=%b d=%0d: got ack=%b err=%b lat=%0d c/w/r=%0d%0d%0d expected %b %b %0d %0d%0d%0d",
                          i, addr, we, d, ga, ge, lat, nc, nw, nr, e_ack, e_err, e_lat, e_c, e_w, e_r);
      end
      tests++;
      if ({rdv, dout} !== {m_wb_din, m_dout}) begin
        fails++; $display("FAIL rand_data %0d: got wb_din=%h dout=%h expected %h %h", i, rdv, dout, m_wb_din, m_dout);
      end
    end
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    m_wb_din = m_stat();
    tests++;
    if (rdv !== m_wb_din) begin
      fails++; $display("FAIL rand_stat: got %h expected %h", rdv, m_wb_din);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ga, ge; int lat, nc, nw, nr; logic [31:0] rdv;
    @(negedge clk);
    bus.wb_addr = A_CMD; bus.wb_we = 1; bus.wb_dout = 32'h0000_0FFF; bus.wb_stb = 1; bus.wb_cyc = 1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.wb_din, bus.wb_ack, bus.wb_err, dout, cmd, wr, rd} !== '0) begin
      fails++; $display("FAIL reset_mid_wait: got din=%h ack=%b err=%b dout=%h cmd=%b wr=%b rd=%b expected all 0",
                        bus.wb_din, bus.wb_ack, bus.wb_err, dout, cmd, wr, rd);
    end
    bus.wb_stb = 0; bus.wb_cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    m_err_cnt = 0; m_to_flag = 0; m_dout = '0; m_wb_din = '0;
    do_access(A_STAT, 0, '0, -1, '0, ga, ge, lat, rdv, nc, nw, nr);
    tests++;
    if ({ga, ge, rdv} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_mid_wait_stat: got ack=%b err=%b data=%h expected 1 0 0", ga, ge, rdv);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_unmapped();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
